// File: rtl/hazard_ctrl_pkg.sv
// Shared instruction-level constants and the hazard-comparison helper
// used by the pipeline hazard unit.
package hazard_ctrl_pkg;

  localparam int WIDTH_INSTR     = 32;
  localparam int WIDTH_REG       = 5;
  localparam int WIDTH_T         = 2;   // Tuse / Tnew range 0..2
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int MDU_CNT_W       = 4;

  typedef enum logic {
    MDU_IDLE,
    MDU_BUSY
  } mdu_state_e;

  // A source stalls only when the producer's result arrives later than the consumer needs it.
  function automatic logic src_hazard(
    input logic                 use_src,
    input logic [WIDTH_REG-1:0] src,
    input logic [WIDTH_REG-1:0] dst,
    input logic [WIDTH_T-1:0]   tuse,
    input logic [WIDTH_T-1:0]   tnew
  );
    return use_src && (src != '0) && (src == dst) && (tnew > tuse);
  endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_timer.sv
// Multiply/divide occupancy timer: IDLE/BUSY FSM with a down-counter.
module mdu_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic startMult,
  input  logic startDiv,
  output logic busy
);

  mdu_state_e             state_q, state_d;
  logic [MDU_CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MDU_IDLE: begin
        // Divide takes priority when both starts arrive together.
        if (startDiv) begin
          state_d = MDU_BUSY;
          cnt_d   = MDU_CNT_W'(DIV_CYCLES);
        end else if (startMult) begin
          state_d = MDU_BUSY;
          cnt_d   = MDU_CNT_W'(MULT_CYCLES);
        end
      end
      MDU_BUSY: begin
        if (cnt_q <= MDU_CNT_W'(1)) begin
          state_d = MDU_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - MDU_CNT_W'(1);
        end
      end
      default: begin
        state_d = MDU_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Busy is visible in the start cycle itself so a dependent ID op stalls immediately.
  assign busy = (state_q == MDU_BUSY) || startMult || startDiv;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-dependency stalls from Tuse/Tnew plus
// multiply/divide occupancy stalls, with a stall-cycle counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH_REG-1:0] addrRs_ID,
  input  logic [WIDTH_REG-1:0] addrRt_ID,
  input  logic                 useRs_ID,
  input  logic                 useRt_ID,
  input  logic [WIDTH_T-1:0]   tuseRs_ID,
  input  logic [WIDTH_T-1:0]   tuseRt_ID,
  input  logic [WIDTH_REG-1:0] regWriteAddr_EX,
  input  logic [WIDTH_REG-1:0] regWriteAddr_MEM,
  input  logic [WIDTH_T-1:0]   tnew_EX,
  input  logic [WIDTH_T-1:0]   tnew_MEM,
  input  logic                 startMult_EX,
  input  logic                 startDiv_EX,
  input  logic                 useMdu_ID,
  output logic                 stall,
  output logic                 clr_EX,
  output logic                 mduBusy,
  output logic [31:0]          stallCount
);

  logic rsStallEX, rsStallMEM, rtStallEX, rtStallMEM;
  logic dataStall, mduStall;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  assign rsStallEX  = src_hazard(useRs_ID, addrRs_ID, regWriteAddr_EX,  tuseRs_ID, tnew_EX);
  assign rsStallMEM = src_hazard(useRs_ID, addrRs_ID, regWriteAddr_MEM, tuseRs_ID, tnew_MEM);
  assign rtStallEX  = src_hazard(useRt_ID, addrRt_ID, regWriteAddr_EX,  tuseRt_ID, tnew_EX);
  assign rtStallMEM = src_hazard(useRt_ID, addrRt_ID, regWriteAddr_MEM, tuseRt_ID, tnew_MEM);

  assign dataStall = rsStallEX | rsStallMEM | rtStallEX | rtStallMEM;

  mdu_timer #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_mdu_timer (
    .clk      (clk),
    .reset    (reset),
    .startMult(startMult_EX),
    .startDiv (startDiv_EX),
    .busy     (mduBusy)
  );

  assign mduStall = useMdu_ID & mduBusy;

  // Freezing IF/ID and bubbling ID/EX always go together.
  assign stall  = dataStall | mduStall;
  assign clr_EX = stall;

  assign stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stallCount = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  addrRs_ID, addrRt_ID;
  logic        useRs_ID, useRt_ID;
  logic [1:0]  tuseRs_ID, tuseRt_ID;
  logic [4:0]  regWriteAddr_EX, regWriteAddr_MEM;
  logic [1:0]  tnew_EX, tnew_MEM;
  logic        startMult_EX, startDiv_EX, useMdu_ID;
  logic        stall, clr_EX, mduBusy;
  logic [31:0] stallCount;

  int nvec  = 0;
  int nfail = 0;

  hazard_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .addrRs_ID       (addrRs_ID),
    .addrRt_ID       (addrRt_ID),
    .useRs_ID        (useRs_ID),
    .useRt_ID        (useRt_ID),
    .tuseRs_ID       (tuseRs_ID),
    .tuseRt_ID       (tuseRt_ID),
    .regWriteAddr_EX (regWriteAddr_EX),
    .regWriteAddr_MEM(regWriteAddr_MEM),
    .tnew_EX         (tnew_EX),
    .tnew_MEM        (tnew_MEM),
    .startMult_EX    (startMult_EX),
    .startDiv_EX     (startDiv_EX),
    .useMdu_ID       (useMdu_ID),
    .stall           (stall),
    .clr_EX          (clr_EX),
    .mduBusy         (mduBusy),
    .stallCount      (stallCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    addrRs_ID = 0; addrRt_ID = 0; useRs_ID = 0; useRt_ID = 0;
    tuseRs_ID = 0; tuseRt_ID = 0;
    regWriteAddr_EX = 0; regWriteAddr_MEM = 0; tnew_EX = 0; tnew_MEM = 0;
    startMult_EX = 0; startDiv_EX = 0; useMdu_ID = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if ({stall, clr_EX, mduBusy} !== 3'b000 || stallCount !== 32'd0) begin
      nfail++;
      $display("FAIL reset: stall=%b clr=%b busy=%b cnt=%0d, want 0 0 0 0",
               stall, clr_EX, mduBusy, stallCount);
    end
  endtask

  // {useRs,rs,tuseRs,useRt,rt,tuseRt,wEX,tnewEX,wMEM,tnewMEM} -> expected stall
  task automatic data_vec(input string name, input logic uRs, input logic [4:0] rs,
                          input logic [1:0] tRs, input logic uRt, input logic [4:0] rt,
                          input logic [1:0] tRt, input logic [4:0] wex, input logic [1:0] nex,
                          input logic [4:0] wmem, input logic [1:0] nmem, input logic exp);
    useRs_ID = uRs; addrRs_ID = rs; tuseRs_ID = tRs;
    useRt_ID = uRt; addrRt_ID = rt; tuseRt_ID = tRt;
    regWriteAddr_EX = wex; tnew_EX = nex; regWriteAddr_MEM = wmem; tnew_MEM = nmem;
    #1;
    nvec++;
    if (stall !== exp || clr_EX !== exp) begin
      nfail++;
      $display("FAIL %s: stall=%b clr=%b, want %b", name, stall, clr_EX, exp);
    end
  endtask

  task automatic test_data_stall();
    do_reset();
    data_vec("rs_ex_stall",   1, 8, 0, 0, 0, 0, 8, 1, 0, 0, 1'b1);
    data_vec("rs_ex_ready",   1, 8, 0, 0, 0, 0, 8, 0, 0, 0, 1'b0);
    data_vec("rt_r0_nostall", 0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 1'b0);
    data_vec("rs_mem_stall",  1, 9, 1, 0, 0, 0, 3, 2, 9, 2, 1'b1);
    data_vec("rs_tnew_eq",    1, 9, 2, 0, 0, 0, 9, 2, 9, 2, 1'b0);
    data_vec("rt_ex_stall",   0, 0, 0, 1, 17, 1, 17, 2, 0, 0, 1'b1);
    data_vec("rt_mem_stall",  0, 0, 0, 1, 31, 0, 0, 0, 31, 1, 1'b1);
    data_vec("rs_unused",     0, 8, 0, 0, 0, 0, 8, 2, 8, 2, 1'b0);
    data_vec("addr_differ",   1, 5, 0, 1, 6, 0, 7, 2, 4, 2, 1'b0);
    idle_inputs();
  endtask

  task automatic test_mult();
    do_reset();
    startMult_EX = 1'b1;
    tick();
    startMult_EX = 1'b0;
    useMdu_ID = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      nvec++;
      if (stall !== 1'b1 || mduBusy !== 1'b1) begin
        nfail++;
        $display("FAIL mult_busy_c%0d: stall=%b busy=%b, want 1 1", k, stall, mduBusy);
      end
      tick();
    end
    nvec++;
    if (stall !== 1'b0 || mduBusy !== 1'b0 || stallCount !== 32'd5) begin
      nfail++;
      $display("FAIL mult_done: stall=%b busy=%b cnt=%0d, want 0 0 5", stall, mduBusy, stallCount);
    end
    idle_inputs();
  endtask

  task automatic test_div_priority();
    do_reset();
    startMult_EX = 1'b1;
    startDiv_EX  = 1'b1;
    tick();
    startMult_EX = 1'b0;
    startDiv_EX  = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) startMult_EX = 1'b1;
      #1;
      nvec++;
      if (mduBusy !== 1'b1) begin
        nfail++;
        $display("FAIL div_busy_c%0d: busy=%b, want 1", k, mduBusy);
      end
      tick();
      startMult_EX = 1'b0;
    end
    #1;
    nvec++;
    if (mduBusy !== 1'b0 || stallCount !== 32'd0) begin
      nfail++;
      $display("FAIL div_done: busy=%b cnt=%0d, want 0 0", mduBusy, stallCount);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    startDiv_EX = 1'b1;
    tick();
    startDiv_EX = 1'b0;
    useMdu_ID = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    nvec++;
    if (stallCount !== 32'd4 || mduBusy !== 1'b1) begin
      nfail++;
      $display("FAIL pre_abort: cnt=%0d busy=%b, want 4 1", stallCount, mduBusy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    nvec++;
    if (mduBusy !== 1'b0 || stall !== 1'b0 || stallCount !== 32'd0) begin
      nfail++;
      $display("FAIL abort: busy=%b stall=%b cnt=%0d, want 0 0 0", mduBusy, stall, stallCount);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    do_reset();
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    #1;
    nvec++;
    if (stallCount !== 32'hFFFF_FFFF) begin
      nfail++;
      $display("FAIL wrap_preload: cnt=%h, want ffffffff", stallCount);
    end
    useRs_ID = 1; addrRs_ID = 8; tuseRs_ID = 0; regWriteAddr_EX = 8; tnew_EX = 1;
    tick();
    idle_inputs();
    #1;
    nvec++;
    if (stallCount !== 32'd0) begin
      nfail++;
      $display("FAIL wrap: cnt=%h, want 00000000", stallCount);
    end
    tick();
    nvec++;
    if (stallCount !== 32'd0) begin
      nfail++;
      $display("FAIL wrap_hold: cnt=%h, want 00000000", stallCount);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    tick();
    test_reset();
    test_data_stall();
    test_mult();
    test_div_priority();
    test_reset_mid_busy();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule
